// File: rtl/cmp_rgb_pkg.sv
// Shared types and the reference compare function for the comparator RGB self-test.
// Holds no logic. W-dependent sizes stay in the modules that use them.
package cmp_rgb_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  // Widest operand expected_rgb accepts; callers zero-extend into it.
  localparam int MAX_W = 16;

  function automatic logic [2:0] expected_rgb(input logic [MAX_W-1:0] a,
                                              input logic [MAX_W-1:0] b);
    return {a > b, a == b, a < b};
  endfunction

endpackage

// File: rtl/cmp_rgb_dwell_timer.sv
// Dwell timer: counts down from DWELL_CYCLES-1 to 0 after each load; last_cycle marks the sample cycle.
// Latency: load takes effect on the next edge. Backpressure: none; en freezes the count.
// Holds at zero once expired; the owner reloads it for each new vector.
module cmp_rgb_dwell_timer #(
  parameter int DWELL_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic last_cycle
);

  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] TOP = CW'(DWELL_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= TOP;
    else if (en && cnt != '0)
      cnt <= cnt - CW'(1);
  end

  assign last_cycle = en && (cnt == '0);

endmodule

// File: rtl/cmp_rgb_sweeper.sv
// Sweeps every (a,b) pair into the comparator, checks the returned RGB one-hot and reports the result.
// Latency: 2^(2W)*DWELL_CYCLES cycles from start to done. Backpressure: start ignored while busy.
module cmp_rgb_sweeper
  import cmp_rgb_pkg::*;
#(
  parameter int W            = 2,
  parameter int DWELL_CYCLES = 4,
  parameter int ERR_W        = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [W-1:0]     a_out,
  output logic [W-1:0]     b_out,
  input  logic             red_in,
  input  logic             green_in,
  input  logic             blue_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [W-1:0]     fail_a,
  output logic [W-1:0]     fail_b
);

  localparam int VW = 2 * W;
  localparam logic [VW-1:0] LAST_VEC = '1;

  state_t          state;
  logic [VW-1:0]   vec;
  logic            last_cycle;
  logic            start_ok;
  logic            sample;
  logic            mismatch;
  logic [2:0]      exp_rgb;
  logic [ERR_W-1:0] err_next;

  // {a,b} is the vector index itself, so a sits in the MSBs.
  assign a_out = vec[VW-1:W];
  assign b_out = vec[W-1:0];

  assign start_ok = start && (state != DRIVE);
  assign sample   = (state == DRIVE) && last_cycle;
  assign exp_rgb  = expected_rgb(MAX_W'(a_out), MAX_W'(b_out));
  assign mismatch = sample && ({red_in, green_in, blue_in} != exp_rgb);
  assign err_next = (mismatch && err_count != '1) ? err_count + ERR_W'(1) : err_count;

  cmp_rgb_dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dwell (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (start_ok || (sample && vec != LAST_VEC)),
    .en        (state == DRIVE),
    .last_cycle(last_cycle)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= DRIVE;
            vec        <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
          end
        end
        DRIVE: begin
          if (sample) begin
            err_count <= err_next;
            // Only the first failing vector is kept.
            if (mismatch && !fail_valid) begin
              fail_valid <= 1'b1;
              fail_a     <= a_out;
              fail_b     <= b_out;
            end
            if (vec == LAST_VEC) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
            end else begin
              vec <= vec + VW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_rgb_sweeper.sv
// Bench: comparator model with selectable faults loops back into the sweeper; a scoreboard
// queue holds hand-computed sweep results that a done-edge monitor pops and compares.
module tb_cmp_rgb_sweeper;

  localparam int W     = 2;
  localparam int D     = 4;
  localparam int NV    = 16;
  localparam int SWEEP = NV * D;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start3 = 1'b0;

  logic [W-1:0] a_out, b_out, fail_a, fail_b;
  logic red, green, blue;
  logic busy, done, pass, fail_valid;
  logic [4:0] err_count;

  logic [W-1:0] a3, b3, fa3, fb3;
  logic busy3, done3, pass3, fv3;
  logic [2:0] err3;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int mode = 0;

  typedef struct {
    int    done_cyc;
    int    err;
    bit    pass;
    bit    fv;
    int    fa;
    int    fb;
    string tag;
  } exp_t;

  exp_t q[$];
  exp_t q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // mode 0: correct, 1: red stuck low, 2: red/blue swapped
  always_comb begin
    red   = a_out > b_out;
    green = a_out == b_out;
    blue  = a_out < b_out;
    case (mode)
      1: red = 1'b0;
      2: begin
        red  = a_out < b_out;
        blue = a_out > b_out;
      end
      default: ;
    endcase
  end

  cmp_rgb_sweeper #(.W(W), .DWELL_CYCLES(D), .ERR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_out(a_out), .b_out(b_out),
    .red_in(red), .green_in(green), .blue_in(blue),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .fail_a(fail_a), .fail_b(fail_b)
  );

  cmp_rgb_sweeper #(.W(W), .DWELL_CYCLES(D), .ERR_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .a_out(a3), .b_out(b3),
    .red_in(1'b0), .green_in(1'b0), .blue_in(1'b0),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .fail_valid(fv3), .fail_a(fa3), .fail_b(fb3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_result(input exp_t e, input int c, input logic [31:0] err, input logic p,
                              input logic fv, input logic [31:0] fa, input logic [31:0] fb,
                              input logic bsy, input logic bsy_q);
    check({e.tag, "_done_cycle"}, 32'(c), 32'(e.done_cyc));
    check({e.tag, "_err_count"}, err, 32'(e.err));
    check({e.tag, "_pass"}, 32'(p), 32'(e.pass));
    check({e.tag, "_fail_valid"}, 32'(fv), 32'(e.fv));
    check({e.tag, "_fail_a"}, fa, 32'(e.fa));
    check({e.tag, "_fail_b"}, fb, 32'(e.fb));
    check({e.tag, "_busy_at_done"}, 32'(bsy), 32'd0);
    check({e.tag, "_busy_before_done"}, 32'(bsy_q), 32'd1);
  endtask

  logic done_q = 1'b0, busy_q = 1'b0;
  always @(negedge clk) begin
    if (done && !done_q) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check_result(e, cyc, 32'(err_count), pass, fail_valid, 32'(fail_a), 32'(fail_b), busy, busy_q);
      end
    end
    done_q = done;
    busy_q = busy;
  end

  logic done3_q = 1'b0, busy3_q = 1'b0;
  always @(negedge clk) begin
    if (done3 && !done3_q) begin
      if (q3.size() == 0) begin
        check("unexpected_done3", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q3.pop_front();
        check_result(e, cyc, 32'(err3), pass3, fv3, 32'(fa3), 32'(fb3), busy3, busy3_q);
      end
    end
    done3_q = done3;
    busy3_q = busy3;
  end

  task automatic do_start(input bit also3, output int se);
    @(negedge clk);
    start = 1'b1;
    start3 = also3;
    @(posedge clk);
    #1;
    se = cyc;
    start = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic push(input int se, input int err, input bit p, input bit fv,
                      input int fa, input int fb, input string tag);
    exp_t e;
    e.done_cyc = se + SWEEP;
    e.err = err;
    e.pass = p;
    e.fv = fv;
    e.fa = fa;
    e.fb = fb;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic wait_sb(input string name);
    int k;
    k = 0;
    while (q.size() != 0 && k < SWEEP + 20) begin
      @(negedge clk);
      k++;
    end
    check({name, "_completed"}, 32'(q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_cleared(input string name);
    check({name, "_busy"}, 32'(busy), 32'd1);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_pass"}, 32'(pass), 32'd0);
    check({name, "_err"}, 32'(err_count), 32'd0);
    check({name, "_fv"}, 32'(fail_valid), 32'd0);
    check({name, "_fab"}, 32'({fail_a, fail_b}), 32'd0);
    check({name, "_vec0"}, 32'({a_out, b_out}), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_outs"}, 32'({a_out, b_out, busy, done, pass, err_count, fail_valid, fail_a, fail_b}), 32'd0);
    check({name, "_outs3"}, 32'({a3, b3, busy3, done3, pass3, err3, fv3, fa3, fb3}), 32'd0);
  endtask

  initial begin
    int se;
    exp_t e3;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: clean sweep, plus the ERR_W=3 instance with all lines low saturating at 7
    while (cyc < 9) @(negedge clk);
    mode = 0;
    do_start(1'b1, se);
    check_cleared("t1_start");
    push(se, 0, 1'b1, 1'b0, 0, 0, "t1");
    e3.done_cyc = se + SWEEP; e3.err = 7; e3.pass = 1'b0; e3.fv = 1'b1;
    e3.fa = 0; e3.fb = 0; e3.tag = "t3_sat";
    q3.push_back(e3);
    wait_sb("t1");

    // 2: red stuck low; first failure is a=1,b=0
    mode = 1;
    do_start(1'b0, se);
    push(se, 6, 1'b0, 1'b1, 1, 0, "t2");
    wait_sb("t2");

    // 6: restart from DONE after a failing sweep
    mode = 0;
    do_start(1'b0, se);
    check_cleared("t6_start");
    push(se, 0, 1'b1, 1'b0, 0, 0, "t6");
    wait_sb("t6");

    // 3: red/blue swapped; the 12 unequal pairs fail, first a=0,b=1
    mode = 2;
    do_start(1'b0, se);
    push(se, 12, 1'b0, 1'b1, 0, 1, "t3");
    wait_sb("t3");

    // 4: a start pulse mid-sweep must not disturb timing
    mode = 0;
    do_start(1'b0, se);
    push(se, 0, 1'b1, 1'b0, 0, 0, "t4");
    while (cyc < se + 19) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t4_busy_after_restart", 32'(busy), 32'd1);
    check("t4_vec_after_restart", 32'({a_out, b_out}), 32'd5);
    wait_sb("t4");

    // 5: reset while vector 5 is driven aborts the sweep
    do_start(1'b0, se);
    while (cyc < se + 21) @(negedge clk);
    check("t5_vec5_a", 32'(a_out), 32'd1);
    check("t5_vec5_b", 32'(b_out), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("t5_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_idle_busy", 32'({busy, done}), 32'd0);
    do_start(1'b0, se);
    push(se, 0, 1'b1, 1'b0, 0, 0, "t5");
    wait_sb("t5");

    check("sat_sweep_completed", 32'(q3.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
